// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the mem_arbiter slice: channel limit, FSM state type
// and the helper that sizes the grant index.
// Optional feature macro: MEM_ARBITER_RR_EN (round-robin policy, used by mem_arbiter).
package mem_arbiter_pkg;

    localparam int ARB_NCH_MAX = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_type;

    // Width of an index into n channels; never below one bit so NCH=1 still has a grant register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational find-first-set over a request mask. The scan starts at
// i_ptr and wraps from NCH-1 back to 0, so a zero pointer gives plain
// lowest-index-wins priority.
// Optional feature macro: MEM_ARBITER_RR_EN (only affects the pointer fed in by mem_arbiter).
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_ptr,
    output logic           o_found,
    output logic [IW-1:0]  o_idx
);

    // Walk the channels in rotated order and keep only the first one that requests.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!o_found && i_req[(int'(i_ptr) + k) % NCH]) begin
                o_found = 1'b1;
                o_idx   = IW'((int'(i_ptr) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges NCH valid/ready request ports onto one shared memory port.
// A registered grant selects which channel's fields drive the memory port; on
// completion the arbiter re-arbitrates among the other channels in the same
// cycle so queued requests follow without a bubble.
// Optional feature macro: MEM_ARBITER_RR_EN selects round-robin arbitration;
// without it the lowest requesting index always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       rst,
    input  logic                       clk,
    input  logic [NCH-1:0]             m_valid,
    input  logic [NCH-1:0]             m_instr,
    input  logic [NCH*ADDR_W-1:0]      m_addr,
    input  logic [NCH*DATA_W-1:0]      m_wdata,
    input  logic [NCH*(DATA_W/8)-1:0]  m_wstrb,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [NCH-1:0]             m_ready,
    output logic                       mem_valid,
    output logic                       mem_instr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_wstrb,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ready
);

    localparam int IW = clog2(NCH);
    localparam int SW = DATA_W / 8;

    arb_state_type   r_state;
    logic [IW-1:0]   r_gnt;
    logic [NCH-1:0]  w_gntOneHot;
    logic            w_complete;
    logic [NCH-1:0]  w_req;
    logic [IW-1:0]   w_ptr;
    logic            w_found;
    logic [IW-1:0]   w_pick;

    assign w_gntOneHot = NCH'(1) << r_gnt;
    assign w_complete  = (r_state == BUSY) && mem_ready;

    // The channel that just completed is masked so it cannot win twice in a row
    // while it is still (legally) holding m_valid during its completion cycle.
    assign w_req = w_complete ? (m_valid & ~w_gntOneHot) : m_valid;

`ifdef MEM_ARBITER_RR_EN
    logic [IW-1:0] r_rrPtr;
    logic [IW-1:0] w_gntNext;

    assign w_gntNext = (r_gnt == IW'(NCH - 1)) ? '0 : r_gnt + IW'(1);
    assign w_ptr     = w_complete ? w_gntNext : r_rrPtr;

    // The round-robin pointer moves just past each channel as it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rrPtr <= '0;
        end else if (w_complete) begin
            r_rrPtr <= w_gntNext;
        end
    end
`else
    assign w_ptr = '0;
`endif

    arb_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (w_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Grant FSM: latch a winner from IDLE, and on completion either hand over
    // directly to the next requester or fall back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_gnt   <= w_pick;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (w_found) begin
                            r_gnt <= w_pick;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Shared port is driven from the granted channel only while BUSY, and held at zero otherwise.
    always_comb begin
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (r_state == BUSY) begin
            mem_valid = 1'b1;
            mem_instr = m_instr[r_gnt];
            mem_addr  = m_addr[int'(r_gnt) * ADDR_W +: ADDR_W];
            mem_wdata = m_wdata[int'(r_gnt) * DATA_W +: DATA_W];
            mem_wstrb = m_wstrb[int'(r_gnt) * SW +: SW];
        end
    end

    assign m_ready = w_complete ? w_gntOneHot : '0;
    assign m_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with four channels. A small memory model
// answers each forwarded request after memLat cycles; every scenario task
// drives its own vectors and compares against hand-computed values.
// Honours MEM_ARBITER_RR_EN for the expected grant order of the contention test.
module tb_mem_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;

    logic                rst;
    logic                clk = 1'b0;
    logic [NCH-1:0]      m_valid;
    logic [NCH-1:0]      m_instr;
    logic [NCH*AW-1:0]   m_addr;
    logic [NCH*DW-1:0]   m_wdata;
    logic [NCH*SW-1:0]   m_wstrb;
    logic [DW-1:0]       m_rdata;
    logic [NCH-1:0]      m_ready;
    logic                mem_valid;
    logic                mem_instr;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [SW-1:0]       mem_wstrb;
    logic [DW-1:0]       mem_rdata;
    logic                mem_ready = 1'b0;

    logic                memAuto;
    logic                spurReq;
    int                  memLat;
    int                  memCount = 0;
    logic [DW-1:0]       rdataVal;

    int passCount  = 0;
    int checkCount = 0;

    mem_arbiter #(
        .NCH    (NCH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .rst       (rst),
        .clk       (clk),
        .m_valid   (m_valid),
        .m_instr   (m_instr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = rdataVal;

    // Memory model: counts cycles of mem_valid and raises mem_ready for one cycle per
    // transaction once memLat cycles have elapsed; in manual mode it just echoes spurReq.
    always begin
        @(posedge clk);
        #2;
        if (!rst) begin
            mem_ready = 1'b0;
            memCount  = 0;
        end else if (!memAuto) begin
            mem_ready = spurReq;
            memCount  = 0;
        end else begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                memCount  = 0;
            end
            if (mem_valid) begin
                memCount = memCount + 1;
                if (memCount >= memLat) begin
                    mem_ready = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        m_valid = '0;
        rst     = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic setChan(input int ch, input logic instr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
        m_instr[ch]          = instr;
        m_addr[ch*AW +: AW]  = addr;
        m_wdata[ch*DW +: DW] = wdata;
        m_wstrb[ch*SW +: SW] = wstrb;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NCH; i++) begin
            setChan(i, 1'b1, 32'hA000_0000 + i, 32'hFFFF_FFFF, 4'hF);
        end
        m_valid = 4'hF;
        rst     = 1'b0;
        tick();
        tick();
        checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL reset_mem_valid: got %b expected 0", mem_valid); else passCount++;
        checkCount++; if (m_ready !== 4'h0) $display("[TB] FAIL reset_m_ready: got %b expected 0000", m_ready); else passCount++;
        checkCount++; if (mem_addr !== 32'h0) $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); else passCount++;
        checkCount++; if (mem_wdata !== 32'h0) $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata); else passCount++;
        checkCount++; if (mem_wstrb !== 4'h0) $display("[TB] FAIL reset_mem_wstrb: got %h expected 0", mem_wstrb); else passCount++;
        checkCount++; if (mem_instr !== 1'b0) $display("[TB] FAIL reset_mem_instr: got %b expected 0", mem_instr); else passCount++;
        m_valid = '0;
        rst     = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int cycles;
        doReset();
        memLat   = 3;
        rdataVal = 32'hDEAD_BEEF;
        setChan(1, 1'b1, 32'h100, 32'h0, 4'h0);
        m_valid = 4'b0010;
        #1;
        checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL single_pre_edge_valid: got %b expected 0", mem_valid); else passCount++;
        tick();
        checkCount++; if (mem_valid !== 1'b1) $display("[TB] FAIL single_latency_valid: got %b expected 1", mem_valid); else passCount++;
        checkCount++; if (mem_addr !== 32'h100) $display("[TB] FAIL single_addr: got %h expected 00000100", mem_addr); else passCount++;
        checkCount++; if (mem_instr !== 1'b1) $display("[TB] FAIL single_instr: got %b expected 1", mem_instr); else passCount++;
        checkCount++; if (m_ready !== 4'h0) $display("[TB] FAIL single_early_ready: got %b expected 0000", m_ready); else passCount++;
        cycles = 1;
        while (m_ready === 4'h0 && cycles < 20) begin
            tick();
            cycles++;
        end
        checkCount++; if (cycles !== 3) $display("[TB] FAIL single_cycles: got %0d expected 3", cycles); else passCount++;
        checkCount++; if (m_ready !== 4'b0010) $display("[TB] FAIL single_m_ready: got %b expected 0010", m_ready); else passCount++;
        checkCount++; if (m_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL single_rdata: got %h expected deadbeef", m_rdata); else passCount++;
        m_valid = '0;
        tick();
        checkCount++; if (m_ready !== 4'h0) $display("[TB] FAIL single_ready_pulse: got %b expected 0000", m_ready); else passCount++;
        checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL single_back_idle: got %b expected 0", mem_valid); else passCount++;
    endtask

    task automatic test_priority();
        doReset();
        memLat   = 1;
        rdataVal = 32'h0BAD_F00D;
        setChan(0, 1'b1, 32'h10, 32'h0, 4'h0);
        setChan(1, 1'b0, 32'h20, 32'h0, 4'h0);
        m_valid = 4'b0011;
        tick();
        checkCount++; if (mem_addr !== 32'h10) $display("[TB] FAIL prio_first_addr: got %h expected 00000010", mem_addr); else passCount++;
        checkCount++; if (mem_instr !== 1'b1) $display("[TB] FAIL prio_first_instr: got %b expected 1", mem_instr); else passCount++;
        checkCount++; if (m_ready !== 4'b0001) $display("[TB] FAIL prio_first_ready: got %b expected 0001", m_ready); else passCount++;
        m_valid = 4'b0010;
        tick();
        checkCount++; if (mem_valid !== 1'b1) $display("[TB] FAIL prio_no_bubble: got %b expected 1", mem_valid); else passCount++;
        checkCount++; if (mem_addr !== 32'h20) $display("[TB] FAIL prio_second_addr: got %h expected 00000020", mem_addr); else passCount++;
        checkCount++; if (mem_instr !== 1'b0) $display("[TB] FAIL prio_second_instr: got %b expected 0", mem_instr); else passCount++;
        checkCount++; if (m_ready !== 4'b0010) $display("[TB] FAIL prio_second_ready: got %b expected 0010", m_ready); else passCount++;
        m_valid = '0;
        tick();
        checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL prio_idle_after: got %b expected 0", mem_valid); else passCount++;
    endtask

    task automatic test_write();
        int cycles;
        logic sawReady0;
        doReset();
        memLat = 2;
        setChan(0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 4'hF);
        setChan(1, 1'b0, 32'h200, 32'h1234_5678, 4'b0011);
        m_valid   = 4'b0010;
        sawReady0 = 1'b0;
        tick();
        checkCount++; if (mem_addr !== 32'h200) $display("[TB] FAIL write_addr: got %h expected 00000200", mem_addr); else passCount++;
        checkCount++; if (mem_wdata !== 32'h1234_5678) $display("[TB] FAIL write_wdata: got %h expected 12345678", mem_wdata); else passCount++;
        checkCount++; if (mem_wstrb !== 4'b0011) $display("[TB] FAIL write_wstrb: got %b expected 0011", mem_wstrb); else passCount++;
        checkCount++; if (mem_instr !== 1'b0) $display("[TB] FAIL write_instr: got %b expected 0", mem_instr); else passCount++;
        cycles = 1;
        while (m_ready === 4'h0 && cycles < 20) begin
            tick();
            cycles++;
        end
        if (m_ready[0] === 1'b1) sawReady0 = 1'b1;
        checkCount++; if (m_ready !== 4'b0010) $display("[TB] FAIL write_ready: got %b expected 0010 after %0d cycles", m_ready, cycles); else passCount++;
        m_valid = '0;
        tick();
        if (m_ready[0] === 1'b1) sawReady0 = 1'b1;
        checkCount++; if (m_ready !== 4'h0) $display("[TB] FAIL write_ready_once: got %b expected 0000", m_ready); else passCount++;
        checkCount++; if (sawReady0 !== 1'b0) $display("[TB] FAIL write_ch0_quiet: got %b expected 0", sawReady0); else passCount++;
    endtask

    task automatic test_reset_mid();
        int cycles;
        doReset();
        memLat = 3;
        setChan(2, 1'b0, 32'h300, 32'h0, 4'h0);
        m_valid = 4'b0100;
        tick();
        checkCount++; if (mem_addr !== 32'h300) $display("[TB] FAIL rstmid_busy_addr: got %h expected 00000300", mem_addr); else passCount++;
        #2;
        rst = 1'b0;
        #1;
        checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL rstmid_async_valid: got %b expected 0", mem_valid); else passCount++;
        checkCount++; if (m_ready !== 4'h0) $display("[TB] FAIL rstmid_async_ready: got %b expected 0000", m_ready); else passCount++;
        checkCount++; if (mem_addr !== 32'h0) $display("[TB] FAIL rstmid_async_addr: got %h expected 0", mem_addr); else passCount++;
        tick();
        rst = 1'b1;
        #1;
        checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL rstmid_idle_on_release: got %b expected 0", mem_valid); else passCount++;
        tick();
        checkCount++; if (mem_valid !== 1'b1) $display("[TB] FAIL rstmid_rearb_valid: got %b expected 1", mem_valid); else passCount++;
        checkCount++; if (mem_addr !== 32'h300) $display("[TB] FAIL rstmid_rearb_addr: got %h expected 00000300", mem_addr); else passCount++;
        cycles = 1;
        while (m_ready === 4'h0 && cycles < 20) begin
            tick();
            cycles++;
        end
        checkCount++; if (m_ready !== 4'b0100) $display("[TB] FAIL rstmid_ready: got %b expected 0100 after %0d cycles", m_ready, cycles); else passCount++;
        m_valid = '0;
        tick();
    endtask

    task automatic test_spurious();
        doReset();
        memAuto = 1'b0;
        spurReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++; if (m_ready !== 4'h0) $display("[TB] FAIL spur_ready_%0d: got %b expected 0000", i, m_ready); else passCount++;
            checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL spur_idle_%0d: got %b expected 0", i, mem_valid); else passCount++;
        end
        spurReq = 1'b0;
        tick();
        memAuto = 1'b1;
        memLat  = 1;
        setChan(0, 1'b0, 32'h40, 32'h0, 4'h0);
        m_valid = 4'b0001;
        tick();
        checkCount++; if (mem_addr !== 32'h40) $display("[TB] FAIL spur_then_addr: got %h expected 00000040", mem_addr); else passCount++;
        checkCount++; if (m_ready !== 4'b0001) $display("[TB] FAIL spur_then_ready: got %b expected 0001", m_ready); else passCount++;
        m_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        int done;
        int cyc;
        int idx;
        int expIdx;
        int perCh[NCH];
        logic [NCH-1:0] expReady;
        doReset();
        memLat = 1;
        for (int i = 0; i < NCH; i++) begin
            setChan(i, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0);
            perCh[i] = 0;
        end
        m_valid = 4'hF;
        done    = 0;
        cyc     = 0;
        while (done < 40 && cyc < 200) begin
            tick();
            cyc++;
            checkCount++; if (mem_valid !== 1'b1) $display("[TB] FAIL b2b_valid_cycle%0d: got %b expected 1", cyc, mem_valid); else passCount++;
            if (m_ready !== 4'h0) begin
`ifdef MEM_ARBITER_RR_EN
                expIdx = done % 4;
`else
                expIdx = done % 2;
`endif
                expReady = 4'b0001 << expIdx;
                checkCount++; if (m_ready !== expReady) $display("[TB] FAIL b2b_order_%0d: got %b expected %b", done, m_ready, expReady); else passCount++;
                checkCount++; if (mem_addr !== 32'h1000 + 32'(expIdx * 4)) $display("[TB] FAIL b2b_addr_%0d: got %h expected %h", done, mem_addr, 32'h1000 + 32'(expIdx * 4)); else passCount++;
                idx = 0;
                for (int b = 0; b < NCH; b++) begin
                    if (m_ready[b] === 1'b1) idx = b;
                end
                perCh[idx] = perCh[idx] + 1;
                done++;
            end
        end
        m_valid = '0;
        checkCount++; if (done !== 40) $display("[TB] FAIL b2b_count: got %0d expected 40", done); else passCount++;
        for (int i = 0; i < NCH; i++) begin
`ifdef MEM_ARBITER_RR_EN
            expIdx = 10;
`else
            expIdx = (i < 2) ? 20 : 0;
`endif
            checkCount++; if (perCh[i] !== expIdx) $display("[TB] FAIL b2b_share_ch%0d: got %0d expected %0d", i, perCh[i], expIdx); else passCount++;
        end
        tick();
        tick();
        checkCount++; if (mem_valid !== 1'b0) $display("[TB] FAIL b2b_drain_idle: got %b expected 0", mem_valid); else passCount++;
    endtask

    initial begin
        rst      = 1'b0;
        m_valid  = '0;
        m_instr  = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        memAuto  = 1'b1;
        spurReq  = 1'b0;
        memLat   = 1;
        rdataVal = '0;
        $display("[TB] mem_arbiter directed test start");
        test_reset();
        test_single();
        test_priority();
        test_write();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter merging several CPU-side valid/ready memory request ports onto one shared memory port.
- Typical use: imem and dmem of the core, plus optional DMA/debug masters, sharing a single SRAM/bus.
- Sits between the cpu top-level memory ports and the memory/bus.
- Generalises the fixed two-port split to NCH channels, with a registered grant and selectable arbitration policy.

Parameters:
NCH, 2, number of requesting channels (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
rst  in  1  asynchronous reset, active-low
clk  in  1  clock
m_valid  in  NCH  per-channel request valid
m_instr  in  NCH  per-channel instruction-fetch flag
m_addr  in  NCH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
m_wdata  in  NCH*DATA_W  per-channel write data
m_wstrb  in  NCH*DATA_W/8  per-channel byte strobes; all-zero means read
m_rdata  out  DATA_W  read data, broadcast to all channels
m_ready  out  NCH  per-channel completion pulse, one-hot or zero
mem_valid  out  1  shared-port request valid
mem_instr  out  1  shared-port instruction flag
mem_addr  out  ADDR_W  shared-port address
mem_wdata  out  DATA_W  shared-port write data
mem_wstrb  out  DATA_W/8  shared-port strobes
mem_rdata  in  DATA_W  shared-port read data
mem_ready  in  1  shared-port completion, single-cycle pulse

Behaviour:
- Master rule: a master holds m_valid and its request fields stable until it sees m_ready; it may drop or re-raise m_valid the cycle after.
- State machine: IDLE, BUSY. Registers: gnt (index), state, rr_ptr.
- IDLE:
  - If any m_valid is set: latch winner into gnt, go to BUSY.
  - mem_valid is 0 in IDLE.
  - Arbitration latency is 1 cycle from request to mem_valid.
- BUSY:
  - mem_valid=1; mem_instr, mem_addr, mem_wdata and mem_wstrb are combinationally muxed from channel gnt.
- Completion (mem_ready=1 in BUSY):
  - m_ready[gnt]=1 for exactly that cycle; m_rdata=mem_rdata.
  - Re-arbitrate in the same cycle among m_valid with bit gnt masked off.
  - If any other channel requests: load new gnt, stay BUSY, giving back-to-back transactions with no bubble (mem_valid stays 1, fields switch next cycle).
  - Otherwise go to IDLE.
- mem_ready in IDLE is ignored; no m_ready is generated.
- m_ready is never asserted for more than one channel. It is never asserted for a channel whose request was not forwarded.
- A granted channel dropping m_valid while BUSY is a protocol violation. The arbiter still waits for mem_ready and does not abort.
- m_rdata always equals mem_rdata, valid only with m_ready.
- Reset, any time including mid-transaction, is asynchronous:
  - state=IDLE, gnt=0, rr_ptr=0.
  - mem_valid=0; mem_addr, mem_wdata, mem_wstrb and mem_instr driven 0.
  - m_ready=0.
- NCH=1: the arbiter degenerates to a registered pass-through with 1-cycle request latency.

Optional Feature:
- MEM_ARBITER_RR_EN defined: round-robin policy.
  - The winner is the first requesting index at or after rr_ptr, wrapping NCH-1 to 0.
  - On each completion, rr_ptr = gnt+1 mod NCH.
  - Masking of the completing channel still applies.
- Not defined: fixed priority, lowest index wins; rr_ptr is absent.

Decomposition:
- Shared package (wires):
  - arb_state_type enum (IDLE, BUSY).
  - Constants ARB_NCH_MAX=8 and the index width function clog2(NCH).
- Natural sub-module arb_pick: combinational find-first-set over a request mask with rotate-by-pointer start. Instantiated once for the grant decision.

Test Plan:
- Single request: ch1 reads addr 0x100 while ch0 is idle; memory returns 0xDEADBEEF after 3 cycles → mem_valid rises 1 cycle after m_valid[1]; m_ready=2'b10 for one cycle with m_rdata=0xDEADBEEF.
- Simultaneous requests, fixed priority: ch0 and ch1 both valid, 1-cycle memory → ch0 completes first, then ch1 back-to-back with mem_valid continuously 1 and no bubble.
- Round-robin, MEM_ARBITER_RR_EN defined, NCH=4: all four channels continuously requesting → grant order 0,1,2,3,0; each channel gets exactly 1 of every 4 completions over 40 transactions.
- Write: ch1 issues wstrb 4'b0011, wdata 0x12345678, addr 0x200 → the memory port sees identical fields; m_ready[1] pulses once; m_ready[0] stays 0.
- Reset mid-transaction: rst low while BUSY on ch2 → mem_valid=0 and m_ready=0 immediately, without waiting for a clock edge; after release, a fresh request from ch2 is re-arbitrated from IDLE.
- Spurious mem_ready in IDLE: inject mem_ready=1 with no request → all m_ready stay 0 and state stays IDLE.
